// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: registered syncs, blanking, position, strobes, frame counter.
// Define VGA_TIMING_CE_CHECK_EN to add a simulation-only pix_ce/parameter/frame-length checker.
module vga_timing_gen #(
   parameter int   H_DISPLAY  = 640,
   parameter int   H_FRONT    = 16,
   parameter int   H_SYNC     = 96,
   parameter int   H_BACK     = 48,
   parameter int   V_DISPLAY  = 480,
   parameter int   V_FRONT    = 10,
   parameter int   V_SYNC     = 2,
   parameter int   V_BACK     = 33,
   parameter logic H_SYNC_POL = 1'b0,
   parameter logic V_SYNC_POL = 1'b0,
   parameter int   POS_W      = 10,
   parameter int   FRAME_W    = 12
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pix_ce,
   output logic               hsync,
   output logic               vsync,
   output logic               display_on,
   output logic               hblank,
   output logic               vblank,
   output logic [POS_W-1:0]   hpos,
   output logic [POS_W-1:0]   vpos,
   output logic               line_start,
   output logic               frame_start,
   output logic [FRAME_W-1:0] frame_count
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam logic [POS_W-1:0] H_LAST   = POS_W'(H_TOTAL - 1);
   localparam logic [POS_W-1:0] V_LAST   = POS_W'(V_TOTAL - 1);
   localparam logic [POS_W-1:0] H_VIS    = POS_W'(H_DISPLAY);
   localparam logic [POS_W-1:0] V_VIS    = POS_W'(V_DISPLAY);
   localparam logic [POS_W-1:0] HS_START = POS_W'(H_DISPLAY + H_FRONT);
   localparam logic [POS_W-1:0] HS_END   = POS_W'(H_DISPLAY + H_FRONT + H_SYNC);
   localparam logic [POS_W-1:0] VS_START = POS_W'(V_DISPLAY + V_FRONT);
   localparam logic [POS_W-1:0] VS_END   = POS_W'(V_DISPLAY + V_FRONT + V_SYNC);

   logic [POS_W-1:0] h_cnt;
   logic [POS_W-1:0] v_cnt;
   logic             first_frame;
   logic             h_zero;
   logic             v_zero;
   logic             hs_active;
   logic             vs_active;

   assign h_zero    = (h_cnt == '0);
   assign v_zero    = (v_cnt == '0);
   assign hs_active = (h_cnt >= HS_START) && (h_cnt < HS_END);
   assign vs_active = (v_cnt >= VS_START) && (v_cnt < VS_END);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (pix_ce) begin
         if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST)
               v_cnt <= '0;
            else
               v_cnt <= v_cnt + POS_W'(1);
         end else begin
            h_cnt <= h_cnt + POS_W'(1);
         end
      end
   end

   // Every output is decoded from the same counter values, so they all describe one pixel.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hpos        <= '0;
         vpos        <= '0;
         hsync       <= ~H_SYNC_POL;
         vsync       <= ~V_SYNC_POL;
         display_on  <= 1'b0;
         hblank      <= 1'b0;
         vblank      <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         frame_count <= '0;
         first_frame <= 1'b1;
      end else begin
         line_start  <= pix_ce & h_zero;
         frame_start <= pix_ce & h_zero & v_zero;
         if (pix_ce) begin
            hpos       <= h_cnt;
            vpos       <= v_cnt;
            hsync      <= hs_active ? H_SYNC_POL : ~H_SYNC_POL;
            vsync      <= vs_active ? V_SYNC_POL : ~V_SYNC_POL;
            display_on <= (h_cnt < H_VIS) && (v_cnt < V_VIS);
            hblank     <= (h_cnt >= H_VIS);
            vblank     <= (v_cnt >= V_VIS);
            // The frame shown right after reset is frame zero, not a completed one.
            if (h_zero && v_zero) begin
               if (first_frame)
                  first_frame <= 1'b0;
               else
                  frame_count <= frame_count + FRAME_W'(1);
            end
         end
      end
   end

`ifdef VGA_TIMING_CE_CHECK_EN
   int ce_per_frame;
   logic ce_armed;

   initial begin
      if ((H_TOTAL - 1) > ((1 << POS_W) - 1) || (V_TOTAL - 1) > ((1 << POS_W) - 1))
         $error("vga_timing_gen: POS_W too small for H_TOTAL/V_TOTAL");
      if (H_SYNC == 0 || V_SYNC == 0)
         $error("vga_timing_gen: zero-width sync pulse");
   end

   always @(posedge clk) begin
      if (rst_n === 1'b1 && $isunknown(pix_ce))
         $error("vga_timing_gen: pix_ce is X out of reset");
      if (!rst_n) begin
         ce_per_frame <= 0;
         ce_armed     <= 1'b0;
      end else if (pix_ce) begin
         if (h_zero && v_zero) begin
            if (ce_armed && ce_per_frame != H_TOTAL * V_TOTAL)
               $error("vga_timing_gen: %0d pix_ce edges in frame, expected %0d",
                      ce_per_frame, H_TOTAL * V_TOTAL);
            ce_armed     <= 1'b1;
            ce_per_frame <= 1;
         end else begin
            ce_per_frame <= ce_per_frame + 1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: a default 640x480 instance and a small 16x8 instance,
// compared every cycle against an arithmetic pixel-index model.
module tb_vga_timing_gen;

   logic clk;
   logic rst_n_s, pix_ce_s;
   logic rst_n_d, pix_ce_d;

   logic       hsync_s, vsync_s, don_s, hbl_s, vbl_s, ls_s, fs_s;
   logic [9:0] hpos_s, vpos_s;
   logic [2:0] fc_s;

   logic        hsync_d, vsync_d, don_d, hbl_d, vbl_d, ls_d, fs_d;
   logic [9:0]  hpos_d, vpos_d;
   logic [11:0] fc_d;

   int checks = 0;
   int errors = 0;

   int   n_s = 0, n_d = 0;
   logic cel_s = 1'b0, cel_d = 1'b0;

   vga_timing_gen #(
      .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
      .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
      .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .POS_W(10), .FRAME_W(3)
   ) dut_small (
      .clk(clk), .rst_n(rst_n_s), .pix_ce(pix_ce_s),
      .hsync(hsync_s), .vsync(vsync_s), .display_on(don_s),
      .hblank(hbl_s), .vblank(vbl_s), .hpos(hpos_s), .vpos(vpos_s),
      .line_start(ls_s), .frame_start(fs_s), .frame_count(fc_s)
   );

   vga_timing_gen dut_def (
      .clk(clk), .rst_n(rst_n_d), .pix_ce(pix_ce_d),
      .hsync(hsync_d), .vsync(vsync_d), .display_on(don_d),
      .hblank(hbl_d), .vblank(vbl_d), .hpos(hpos_d), .vpos(vpos_d),
      .line_start(ls_d), .frame_start(fs_d), .frame_count(fc_d)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference bookkeeping: number of pix_ce edges since reset and whether the last edge had pix_ce.
   always @(posedge clk) begin
      if (!rst_n_s) begin
         n_s <= 0; cel_s <= 1'b0;
      end else begin
         if (pix_ce_s) n_s <= n_s + 1;
         cel_s <= pix_ce_s;
      end
      if (!rst_n_d) begin
         n_d <= 0; cel_d <= 1'b0;
      end else begin
         if (pix_ce_d) n_d <= n_d + 1;
         cel_d <= pix_ce_d;
      end
   end

   function automatic logic [38:0] model(input int n, input logic ce_last,
                                         input int hd, input int hf, input int hs, input int hb,
                                         input int vd, input int vf, input int vs, input int vb,
                                         input logic hp, input logic vp, input int fmod);
      int ht, vt, p, h, v, f;
      logic hsa, vsa;
      ht = hd + hf + hs + hb;
      vt = vd + vf + vs + vb;
      if (n == 0)
         return {~hp, ~vp, 5'b0, 10'd0, 10'd0, 12'd0};
      p = (n - 1) % (ht * vt);
      h = p % ht;
      v = p / ht;
      f = ((n - 1) / (ht * vt)) % fmod;
      hsa = (h >= hd + hf) && (h < hd + hf + hs);
      vsa = (v >= vd + vf) && (v < vd + vf + vs);
      return {hsa ? hp : ~hp, vsa ? vp : ~vp, (h < hd) && (v < vd), h >= hd, v >= vd,
              ce_last && (h == 0), ce_last && (p == 0), 10'(h), 10'(v), 12'(f)};
   endfunction

   function automatic logic [38:0] exp_small();
      return model(n_s, cel_s, 8, 2, 3, 3, 4, 1, 2, 1, 1'b1, 1'b1, 8);
   endfunction

   function automatic logic [38:0] exp_def();
      return model(n_d, cel_d, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 4096);
   endfunction

   function automatic logic [38:0] act_small();
      return {hsync_s, vsync_s, don_s, hbl_s, vbl_s, ls_s, fs_s, hpos_s, vpos_s, 9'd0, fc_s};
   endfunction

   function automatic logic [38:0] act_def();
      return {hsync_d, vsync_d, don_d, hbl_d, vbl_d, ls_d, fs_d, hpos_d, vpos_d, fc_d};
   endfunction

   task automatic tick_s(input logic ce, input logic rn);
      pix_ce_s = ce;
      rst_n_s  = rn;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tick_s(1'b1, 1'b0);
      tick_s(1'b1, 1'b0);
      checks++;
      if (act_small() !== exp_small()) begin
         errors++;
         $display("[TB] FAIL reset_small got %h exp %h", act_small(), exp_small());
      end
      checks++;
      if (act_def() !== exp_def()) begin
         errors++;
         $display("[TB] FAIL reset_default got %h exp %h", act_def(), exp_def());
      end
   endtask

   task automatic test_default_mode();
      int hs_low, don_cnt, fs_cnt;
      hs_low = 0; don_cnt = 0; fs_cnt = 0;
      rst_n_d = 1'b1;
      for (int i = 0; i < 2400; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (act_def() !== exp_def()) begin
            errors++;
            $display("[TB] FAIL default_cycle %0d got %h exp %h", i, act_def(), exp_def());
         end
         if (i < 800) begin
            if (hsync_d == 1'b0) hs_low++;
            if (don_d) don_cnt++;
         end
         if (fs_d) fs_cnt++;
      end
      checks++;
      if (hs_low !== 96) begin
         errors++;
         $display("[TB] FAIL default_hsync_width got %0d exp 96", hs_low);
      end
      checks++;
      if (don_cnt !== 640) begin
         errors++;
         $display("[TB] FAIL default_display_per_line got %0d exp 640", don_cnt);
      end
      checks++;
      if (fs_cnt !== 1) begin
         errors++;
         $display("[TB] FAIL default_frame_start_count got %0d exp 1", fs_cnt);
      end
   endtask

   task automatic test_full_rate_frames();
      int fs_cyc[$];
      logic [2:0] fc_seen[$];
      tick_s(1'b0, 1'b0);
      for (int i = 0; i < 9 * 128; i++) begin
         tick_s(1'b1, 1'b1);
         checks++;
         if (act_small() !== exp_small()) begin
            errors++;
            $display("[TB] FAIL full_rate_cycle %0d got %h exp %h", i, act_small(), exp_small());
         end
         if (fs_s) begin
            fs_cyc.push_back(i);
            fc_seen.push_back(fc_s);
         end
      end
      checks++;
      if (fc_seen.size() !== 9) begin
         errors++;
         $display("[TB] FAIL frame_pulses got %0d exp 9", fc_seen.size());
      end
      for (int k = 0; k < fc_seen.size(); k++) begin
         checks++;
         if (fc_seen[k] !== 3'(k % 8)) begin
            errors++;
            $display("[TB] FAIL frame_count_seq[%0d] got %0d exp %0d", k, fc_seen[k], k % 8);
         end
         if (k > 0) begin
            checks++;
            if (fs_cyc[k] - fs_cyc[k-1] !== 128) begin
               errors++;
               $display("[TB] FAIL full_rate_period got %0d exp 128", fs_cyc[k] - fs_cyc[k-1]);
            end
         end
      end
   endtask

   task automatic test_sparse_ce();
      int fs_cyc[$];
      int ls_run;
      tick_s(1'b0, 1'b0);
      ls_run = 0;
      for (int i = 0; i <= 1024; i++) begin
         tick_s((i % 4) == 0, 1'b1);
         checks++;
         if (act_small() !== exp_small()) begin
            errors++;
            $display("[TB] FAIL sparse_cycle %0d got %h exp %h", i, act_small(), exp_small());
         end
         ls_run = ls_s ? ls_run + 1 : 0;
         if (ls_run > 1) begin
            errors++;
            $display("[TB] FAIL sparse_line_start_width got %0d exp 1", ls_run);
         end
         if (fs_s) fs_cyc.push_back(i);
      end
      checks++;
      if (fs_cyc.size() !== 3) begin
         errors++;
         $display("[TB] FAIL sparse_frame_pulses got %0d exp 3", fs_cyc.size());
      end else begin
         checks++;
         if (fs_cyc[1] - fs_cyc[0] !== 512 || fs_cyc[2] - fs_cyc[1] !== 512) begin
            errors++;
            $display("[TB] FAIL sparse_period got %0d/%0d exp 512",
                     fs_cyc[1] - fs_cyc[0], fs_cyc[2] - fs_cyc[1]);
         end
      end
   endtask

   task automatic test_random_ce();
      tick_s(1'b0, 1'b0);
      for (int i = 0; i < 1500; i++) begin
         tick_s($urandom_range(0, 2) != 0, 1'b1);
         checks++;
         if (act_small() !== exp_small()) begin
            errors++;
            $display("[TB] FAIL random_cycle %0d got %h exp %h", i, act_small(), exp_small());
         end
      end
   endtask

   task automatic test_midframe_reset();
      tick_s(1'b0, 1'b0);
      for (int i = 0; i < 54; i++) tick_s(1'b1, 1'b1);
      checks++;
      if (hpos_s !== 10'd5 || vpos_s !== 10'd3) begin
         errors++;
         $display("[TB] FAIL midframe_position got (%0d,%0d) exp (5,3)", hpos_s, vpos_s);
      end
      tick_s(1'b1, 1'b0);
      checks++;
      if (act_small() !== {2'b00, 5'b0, 10'd0, 10'd0, 12'd0}) begin
         errors++;
         $display("[TB] FAIL midframe_reset_values got %h exp %h", act_small(),
                  {2'b00, 5'b0, 10'd0, 10'd0, 12'd0});
      end
      for (int i = 0; i < 3; i++) begin
         tick_s(1'b0, 1'b1);
         checks++;
         if (act_small() !== exp_small()) begin
            errors++;
            $display("[TB] FAIL midframe_idle %0d got %h exp %h", i, act_small(), exp_small());
         end
      end
      tick_s(1'b1, 1'b1);
      checks++;
      if (hpos_s !== 10'd0 || vpos_s !== 10'd0 || fs_s !== 1'b1 || ls_s !== 1'b1 ||
          fc_s !== 3'd0 || don_s !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midframe_first_pixel got pos(%0d,%0d) fs %b ls %b fc %0d don %b exp pos(0,0) fs 1 ls 1 fc 0 don 1",
                  hpos_s, vpos_s, fs_s, ls_s, fc_s, don_s);
      end
   endtask

   initial begin
      rst_n_s  = 1'b0;
      pix_ce_s = 1'b0;
      rst_n_d  = 1'b0;
      pix_ce_d = 1'b1;
      test_reset();
      test_default_mode();
      test_full_rate_frames();
      test_sparse_ce();
      test_random_ce();
      test_midframe_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised raster timing generator; successor to the fixed 640x480 sync generator.
- Produces hsync, vsync, display_on, hblank, vblank, pixel position, line/frame start strobes and a clk-domain frame counter.
- Supports any mode geometry, per-axis sync polarity and a pixel clock-enable for clk > pixel rate.
- Sits between the clock/reset pins and the pattern/pixel pipelines; replaces vsync-clocked frame counters.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- H_SYNC_POL, 0, hsync active level (0 = active-low)
- V_SYNC_POL, 0, vsync active level
- POS_W, 10, width of hpos/vpos; must hold H_TOTAL-1 and V_TOTAL-1
- FRAME_W, 12, frame counter width

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- pix_ce  in  1  pixel clock enable; tie 1 for clk = pixel clock
- hsync  out  1  horizontal sync at H_SYNC_POL active level
- vsync  out  1  vertical sync at V_SYNC_POL active level
- display_on  out  1  high when hpos < H_DISPLAY and vpos < V_DISPLAY
- hblank  out  1  high when hpos >= H_DISPLAY
- vblank  out  1  high when vpos >= V_DISPLAY
- hpos  out  POS_W  current pixel column
- vpos  out  POS_W  current line
- line_start  out  1  one-clk pulse when outputs first show hpos = 0
- frame_start  out  1  one-clk pulse when outputs first show (0,0)
- frame_count  out  FRAME_W  completed frames since reset

Behaviour:
- Totals: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK; V_TOTAL is the equivalent sum.
- Internal counters h_cnt in 0..H_TOTAL-1 and v_cnt in 0..V_TOTAL-1 step only on clk edges with pix_ce = 1.
- On such an edge, h_cnt wraps to 0 from H_TOTAL-1. v_cnt increments only when h_cnt wraps, and wraps to 0 from V_TOTAL-1.
- Output stage is registered and loads only on edges with pix_ce = 1:
  - hpos/vpos take h_cnt/v_cnt.
  - display_on, hblank and vblank are decoded from the same h_cnt/v_cnt, so all outputs describe the same pixel.
  - Latency: outputs lag the counters by one pix_ce step.
- hsync is active when H_DISPLAY+H_FRONT <= hpos < H_DISPLAY+H_FRONT+H_SYNC.
- vsync is active when V_DISPLAY+V_FRONT <= vpos < V_DISPLAY+V_FRONT+V_SYNC; it depends on vpos only and spans whole lines.
- Strobes:
  - line_start <= pix_ce & (h_cnt == 0).
  - frame_start <= pix_ce & (h_cnt == 0) & (v_cnt == 0).
  - Strobes are cleared on any edge with pix_ce = 0, so each is exactly one clk wide even when pix_ce is sparse.
  - Other outputs hold while pix_ce = 0.
- frame_count:
  - Increments on every edge that loads frame_start = 1, except the first one after reset; a first-frame flag, set by reset, marks that edge.
  - It therefore changes in the same clk that frame_start rises.
  - Wraps modulo 2^FRAME_W.
- Reset (rst_n = 0 at a clk edge) overrides pix_ce and applies mid-frame without restriction:
  - h_cnt = v_cnt = 0, hpos = vpos = 0, frame_count = 0, first-frame flag set.
  - hsync = ~H_SYNC_POL, vsync = ~V_SYNC_POL.
  - display_on = 0, hblank = vblank = 0, line_start = frame_start = 0.
- First pix_ce edge after reset: outputs show (0,0), display_on = 1, line_start = 1, frame_start = 1, frame_count = 0.
- No combinational path from any input to any output.

Optional Feature:
- Macro: VGA_TIMING_CE_CHECK_EN.
- Defined: adds a simulation-only checker, excluded from synthesis.
  - Flags $error if pix_ce is X while rst_n = 1.
  - Flags $error if a parameter set gives H_TOTAL-1 or V_TOTAL-1 beyond 2^POS_W-1, or H_SYNC = 0 / V_SYNC = 0.
  - Counts pix_ce edges per frame and errors if the count differs from H_TOTAL*V_TOTAL.
- Not defined: no checker logic. Functional behaviour is identical.

Test Plan:
- Defaults, pix_ce = 1, rst_n low 2 clks then high → the first clk shows hpos = 0, vpos = 0, frame_start = 1, display_on = 1. frame_start repeats every 800*525 = 420000 clks, and frame_count reads 1 at the second pulse.
- Defaults → hsync low exactly for hpos 656..751 (96 clks/line); vsync low exactly for vpos 490..491; display_on high for 640*480 pixels/frame.
- Small mode (H 8/2/3/3, V 4/1/2/1, H_SYNC_POL = 1), pix_ce = 1 → H_TOTAL = 16, V_TOTAL = 8. hsync high at hpos 10..12; vsync high at vpos 5..6; hblank high at hpos 8..15; frame_start period is 128 clks.
- Small mode, pix_ce high every 4th clk → position advances once per 4 clks; line_start/frame_start are exactly 1 clk wide; the frame period is 512 clks.
- Small mode, FRAME_W = 3, run 9 frames → frame_count sequence 0,1,…,7,0 aligned with frame_start.
- Small mode, assert rst_n low at hpos = 5, vpos = 3 for 1 clk → the next clk shows reset values. The first pix_ce edge after release shows (0,0) with frame_start = 1 and frame_count = 0.
